// File: rtl/sipo.sv
// -----------------------------------------------------------------------------
// sipo: serial-in / parallel-out word assembler.
//
// Chunks of IN_WIDTH bits arrive MSB chunk first and are collected in an
// assembly buffer. When the last chunk of a word is accepted, the whole word
// moves to a held output register. The assembly buffer can already take the
// next word while the previous word waits for the consumer.
//
// Ports:
//   i_clk     sole clock, rising edge
//   i_rst_n   synchronous active-low reset
//   i_flush   synchronous discard of the partial word and the held word
//   i_data    serial chunk (IN_WIDTH)
//   i_valid   i_data is valid
//   o_ready   chunk is accepted this cycle when i_valid && o_ready
//   o_data    assembled word (OUT_WIDTH)
//   o_valid   o_data holds a complete word
//   i_ready   consumer takes the word when o_valid && i_ready
//   o_busy    assembly buffer holds a partial word
// -----------------------------------------------------------------------------
module sipo #(
    parameter int IN_WIDTH  = 8,
    parameter int N_CHUNKS  = 4,
    parameter int OUT_WIDTH = IN_WIDTH * N_CHUNKS
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_flush,
    input  logic [IN_WIDTH-1:0]  i_data,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic [OUT_WIDTH-1:0] o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_busy
);
    localparam int IDX_W = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_CHUNKS - 1);

    // Slot N_CHUNKS-1 is the MSB chunk, so chunk k lands in slot LAST-k.
    logic [N_CHUNKS-1:0][IN_WIDTH-1:0] asm_q;
    logic [N_CHUNKS-1:0][IN_WIDTH-1:0] word;
    logic [IDX_W-1:0]                  idx_q;

    logic clr, last, accept, complete;

    assign clr      = ~i_rst_n | i_flush;
    assign last     = (idx_q == LAST);
    // The last chunk can only go in if the output register is free or is
    // being drained this very cycle; earlier chunks never touch it.
    assign o_ready  = ~clr & ~(last & o_valid & ~i_ready);
    assign accept   = i_valid & o_ready;
    assign complete = accept & last;
    assign o_busy   = (idx_q != '0);

    // Completed word: the buffered chunks plus the chunk arriving now.
    always_comb begin
        word    = asm_q;
        word[0] = i_data;
    end

    always_ff @(posedge i_clk) begin
        if (clr) begin
            idx_q   <= '0;
            asm_q   <= '0;
            o_data  <= '0;
            o_valid <= 1'b0;
        end else begin
            if (accept) begin
                if (last) begin
                    idx_q  <= '0;
                    asm_q  <= '0;
                    o_data <= word;
                end else begin
                    asm_q[LAST - idx_q] <= i_data;
                    idx_q               <= idx_q + IDX_W'(1);
                end
            end
            // A completion replaces the word being handed off, so valid stays up.
            if (complete)
                o_valid <= 1'b1;
            else if (o_valid && i_ready)
                o_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sipo.sv
module tb_sipo;
    localparam int IW = 8;
    localparam int NC = 4;
    localparam int OW = IW * NC;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          valid = 1'b0;
    logic          rdy = 1'b0;
    logic [IW-1:0] din = '0;
    logic          o_ready, o_valid, o_busy;
    logic [OW-1:0] o_data;

    sipo #(.IN_WIDTH(IW), .N_CHUNKS(NC)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .i_flush(flush),
        .i_data (din),
        .i_valid(valid),
        .o_ready(o_ready),
        .o_data (o_data),
        .o_valid(o_valid),
        .i_ready(rdy),
        .o_busy (o_busy)
    );

    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    // Reference model: chunks of the word in progress, words awaiting the
    // consumer, and whether a finished word is currently being offered.
    logic [IW-1:0] part[$];
    logic [OW-1:0] exp_q[$];
    bit            m_held = 1'b0;
    bit            mon_en = 1'b0;

    function automatic bit m_ready();
        return rst_n && !flush && !(part.size() == NC-1 && m_held && !rdy);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on the active edge, using the inputs driven for that edge.
    always @(posedge clk) begin
        bit            acc;
        bit            done;
        logic [OW-1:0] w;
        if (!rst_n || flush) begin
            part.delete();
            exp_q.delete();
            m_held = 1'b0;
        end else begin
            acc  = valid && m_ready();
            done = 1'b0;
            if (acc) begin
                part.push_back(din);
                if (part.size() == NC) begin
                    w = '0;
                    foreach (part[k]) w = (w << IW) | OW'(part[k]);
                    exp_q.push_back(w);
                    part.delete();
                    done = 1'b1;
                end
            end
            if (done)
                m_held = 1'b1;
            else if (m_held && rdy)
                m_held = 1'b0;
        end
    end

    // Monitor on the falling edge: compare what the DUT presents, and retire
    // the offered word when the consumer will take it at the next edge.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("o_ready", 64'(o_ready), 64'(m_ready()));
            chk("o_busy", 64'(o_busy), 64'(part.size() != 0));
            chk("o_valid", 64'(o_valid), 64'(m_held));
            if (o_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errs++;
                    $display("FAIL o_data: word %0h shown, none expected at %0t", o_data, $time);
                end else begin
                    chk("o_data", 64'(o_data), 64'(exp_q[0]));
                end
            end
            if (m_held && rdy && rst_n && !flush && exp_q.size() != 0)
                void'(exp_q.pop_front());
        end
    end

    task automatic step(input bit v, input logic [IW-1:0] d, input bit r,
                        input bit f = 1'b0, input bit rs = 1'b1);
        valid = v; din = d; rdy = r; flush = f; rst_n = rs;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [IW-1:0] seq[4];
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        chk("reset o_data", 64'(o_data), 64'h0);
        chk("reset o_valid", 64'(o_valid), 64'h0);
        chk("reset o_busy", 64'(o_busy), 64'h0);
        chk("reset o_ready", 64'(o_ready), 64'h0);

        // Single word, then o_valid must drop after one cycle.
        seq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        foreach (seq[i]) step(1, seq[i], 1);
        chk("w1 data", 64'(o_data), 64'hAABBCCDD);
        chk("w1 valid", 64'(o_valid), 64'h1);
        step(0, 0, 1);
        chk("w1 valid one cycle", 64'(o_valid), 64'h0);

        // Two words back to back.
        for (int i = 1; i <= 8; i++) begin
            step(1, IW'(i), 1);
            if (i == 4) chk("stream w1", 64'(o_data), 64'h01020304);
            if (i == 8) chk("stream w2", 64'(o_data), 64'h05060708);
        end
        step(0, 0, 1);

        // Held word with consumer stalled; next word fills up behind it.
        seq = '{8'h11, 8'h22, 8'h33, 8'h44};
        foreach (seq[i]) step(1, seq[i], 0);
        seq = '{8'h55, 8'h66, 8'h77, 8'h88};
        for (int i = 0; i < 3; i++) step(1, seq[i], 0);
        chk("stall busy", 64'(o_busy), 64'h1);
        step(1, 8'h88, 0);
        chk("stall ready low", 64'(o_ready), 64'h0);
        chk("stall hold", 64'(o_data), 64'h11223344);
        rdy = 1'b1;
        #1;
        chk("release ready", 64'(o_ready), 64'h1);
        step(1, 8'h88, 1);
        chk("release data", 64'(o_data), 64'h55667788);
        chk("release valid", 64'(o_valid), 64'h1);
        step(0, 0, 1);

        // Flush mid-word.
        step(1, 8'hAA, 1);
        step(1, 8'hBB, 1);
        step(0, 0, 1, 1);
        chk("flush busy", 64'(o_busy), 64'h0);
        seq = '{8'h11, 8'h22, 8'h33, 8'h44};
        foreach (seq[i]) step(1, seq[i], 1);
        chk("post flush", 64'(o_data), 64'h11223344);

        // Flush and valid together: chunk dropped.
        step(1, 8'h99, 1, 1);
        chk("flush clears", 64'(o_data), 64'h0);
        seq = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        foreach (seq[i]) step(1, seq[i], 1);
        chk("flush drop", 64'(o_data), 64'hA1B2C3D4);

        // Reset mid-word.
        step(1, 8'h01, 1);
        step(1, 8'h02, 1);
        valid = 1'b1; din = 8'h03; rst_n = 1'b0;
        #1;
        chk("rst ready", 64'(o_ready), 64'h0);
        @(posedge clk);
        #1;
        chk("rst data", 64'(o_data), 64'h0);
        chk("rst valid", 64'(o_valid), 64'h0);
        chk("rst busy", 64'(o_busy), 64'h0);
        seq = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};
        foreach (seq[i]) step(1, seq[i], 1);
        chk("post rst", 64'(o_data), 64'h0A0B0C0D);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 99) < 70, IW'($urandom), $urandom_range(0, 99) < 60,
                 $urandom_range(0, 99) < 2, $urandom_range(0, 99) >= 1);
        repeat (4) step(0, 0, 1);
        chk("drained", 64'(o_valid), 64'h0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
